// File: rtl/vram_pkg.sv
// Shared VRAM definitions: slot encoding and default RAM geometry,
// used by the arbiter and by the VGA top level.
package vram_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VRD  = 2'd1,
        CWR  = 2'd2
    } slot_t;

endpackage

// File: rtl/vram_wfifo.sv
// Synchronous CPU write buffer for the VRAM arbiter: power-of-two depth,
// head-of-queue visible on rdata, push rejected while full.
module vram_wfifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == CNT_ZERO);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next pointer and occupancy; pointers wrap naturally at the power-of-two depth
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, cleared on reset so discarded writes cannot resurface
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads win every slot, buffered CPU writes
// drain into idle slots. Optional dropped-write counter: VRAM_ARB_DROPCNT_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_50mhz,
    input  logic              rst_n,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_valid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_ARB_DROPCNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FIFO_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    slot_t             slot_q, slot_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              vga_valid_q, vga_valid_d;

    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [FIFO_W-1:0] fifo_head_s;
    logic [FIFO_W-1:0] wr_entry_s;
    logic              bypass_s;

    vram_wfifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk   (clk_50mhz),
        .rst_n (rst_n),
        .push  (fifo_push_s),
        .wdata ({cpu_addr, cpu_wdata}),
        .pop   (fifo_pop_s),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Slot decision; an idle slot with an empty buffer writes the incoming request directly
    always_comb begin
        slot_d      = IDLE;
        fifo_push_s = 1'b0;
        fifo_pop_s  = 1'b0;
        bypass_s    = cpu_we && !vga_req && fifo_empty_s;
        if (vga_req) begin
            slot_d = VRD;
        end else if (!fifo_empty_s || cpu_we) begin
            slot_d = CWR;
        end else begin
            slot_d = IDLE;
        end
        if (fifo_empty_s) begin
            wr_entry_s = {cpu_addr, cpu_wdata};
        end else begin
            wr_entry_s = fifo_head_s;
        end
        fifo_push_s = cpu_we && !fifo_full_s && !bypass_s;
        fifo_pop_s  = (slot_d == CWR) && !fifo_empty_s;
    end

    // RAM pin values for the slot being issued; address/data hold when idle
    always_comb begin
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        vga_valid_d = (slot_q == VRD);
        case (slot_d)
            VRD: begin
                ram_en_d   = 1'b1;
                ram_addr_d = vga_addr;
            end
            CWR: begin
                ram_en_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = wr_entry_s[FIFO_W-1:DATA_W];
                ram_wdata_d = wr_entry_s[DATA_W-1:0];
            end
            IDLE: begin
                ram_en_d = 1'b0;
            end
            default: begin
                ram_en_d = 1'b0;
            end
        endcase
    end

    // Slot and RAM pin registers
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= IDLE;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= {ADDR_W{1'b0}};
            ram_wdata_q <= {DATA_W{1'b0}};
            vga_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            vga_valid_q <= vga_valid_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign vga_valid = vga_valid_q;
    assign vga_rdata = ram_rdata;
    assign cpu_busy  = (fifo_count_s == CNT_FULL);

`ifdef VRAM_ARB_DROPCNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of writes offered while the buffer was full
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (cpu_we && cpu_busy && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter placed between the VGA scanout engine and the CPU bus write path (`Memwrite`/`Addrin`/`BUS`). Scanout reads get absolute priority so pixel fetch never misses its deadline. CPU writes are buffered in a small FIFO and drained into idle RAM cycles. The block owns all RAM control pins; neither requester touches the RAM directly.

## Interface
- `ADDR_W`, 13, RAM word address width
- `DATA_W`, 8, RAM data width
- `FIFO_DEPTH`, 4, CPU write buffer entries (power of two, ≥2)

- `clk_50mhz` in 1: system clock, all logic on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `cpu_we` in 1: write request, one entry per cycle when high
- `cpu_addr` in ADDR_W: write address
- `cpu_wdata` in DATA_W: write data
- `cpu_busy` out 1: FIFO full; `cpu_we` this cycle is dropped
- `vga_req` in 1: scanout read request
- `vga_addr` in ADDR_W: scanout read address
- `vga_rdata` out DATA_W: read data (combinational passthrough of `ram_rdata`)
- `vga_valid` out 1: `vga_rdata` valid this cycle
- `ram_en`, `ram_we` out 1 each: RAM strobe / write enable (registered)
- `ram_addr` out ADDR_W, `ram_wdata` out DATA_W: RAM address/data (registered)
- `ram_rdata` in DATA_W: RAM read data, 1-cycle latency after `ram_en & ~ram_we`

## Operation
- Slot state register `slot` ∈ {IDLE, VRD, CWR} describes the RAM operation issued in the current cycle.
- Decision at each edge: `vga_req` → VRD (capture `vga_addr`); else FIFO non-empty → CWR (pop head, drive addr/data, `ram_we`=1); else IDLE (`ram_en`=0).
- VGA never waits or is stalled; a CPU write may wait indefinitely while `vga_req` is held.
- FIFO: push when `cpu_we & ~cpu_busy`; pop on CWR decision. `cpu_busy` = (count == FIFO_DEPTH), from registered count. When full, push is rejected even if a pop occurs the same cycle.
- Push and pop same cycle with FIFO non-full: count unchanged, order preserved.
- Pointers wrap modulo FIFO_DEPTH; count is log2(DEPTH)+1 bits.
- Write-then-read same address: ordering not guaranteed; the CPU polls or tolerates one stale frame pixel.
- Reset (any time, including mid-operation): FIFO emptied, pending writes discarded, `slot`=IDLE; `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`, `vga_valid`, `cpu_busy` all 0.

## Timing
- VGA read: `vga_req` sampled at edge N → `ram_en`=1, `ram_we`=0 in cycle N+1 → `vga_valid`=1 with data in cycle N+2. Latency 2, throughput 1/cycle.
- CPU write: pushed at edge N into empty FIFO with `vga_req` low → RAM write in cycle N+1 (earliest). Then `cpu_busy` reflects count after the edge.
- `vga_valid` is a 2-stage delay of `vga_req`; no dependency on CPU traffic.
- No combinational path from any input to any RAM output.

## Configuration
- `VRAM_ARB_DROPCNT_EN` defined: adds output `drop_cnt` [15:0], incremented on each `cpu_we & cpu_busy`, saturating at 16'hFFFF, cleared by reset.
- Undefined: port and counter absent; dropped writes are silent.

## Structure
- Shared package `vram_pkg`: `slot_t` enum (IDLE, VRD, CWR), default ADDR_W/DATA_W constants used also by the VGA top.
- One sub-module: `vram_wfifo` (synchronous FIFO, width ADDR_W+DATA_W, full/empty/count). Arbiter logic stays in `vram_arbiter`.

## Test plan
- Reset mid-write with 3 entries queued → all outputs 0 during reset; after release, no RAM write issued.
- Single write addr 0x0010 data 0xA5, no VGA → `ram_we`=1 at 0x0010/0xA5 exactly one cycle after push.
- `vga_req` held for 10 cycles while 4 writes pushed → `cpu_busy`=1 after 4th push; no `ram_we` until `vga_req` drops; then 4 writes issue in order on consecutive cycles.
- Fifth write while full → dropped; with `VRAM_ARB_DROPCNT_EN`, `drop_cnt`=1.
- Read addr 0x1FFF preloaded 0x3C → `vga_valid`=1, `vga_rdata`=0x3C two cycles after `vga_req`.
- Alternating `vga_req` with continuous `cpu_we` → writes fill only gaps; FIFO pointer wrap verified over 20 entries with data order intact.
